// File: rtl/mem_result_checker_if.sv
// Read bus between the result checker and the two memories it scans
// (data memory under test and the answer memory). The checker drives
// the request side; both memories return a word one cycle after rd_req.
interface mem_result_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              rd_req;
    logic [IDX_W-1:0]  rd_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] dut_rdata;
    logic [DATA_W-1:0] ans_rdata;

    modport master (
        output rd_req,
        output rd_idx,
        output rd_addr,
        input  dut_rdata,
        input  ans_rdata
    );

    modport slave (
        input  rd_req,
        input  rd_idx,
        input  rd_addr,
        output dut_rdata,
        output ans_rdata
    );
endinterface

// File: rtl/mem_result_checker.sv
// End-of-program memory checker. After an arm pulse it watches the fetch
// address for the end-of-text address, gives up after a cycle budget,
// and otherwise streams DEPTH words of data memory and answer memory
// through a one-cycle compare stage, recording error count, first
// mismatch and the number of cycles the program ran.
module mem_result_checker #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 32,
    parameter int                CNT_W     = 16,
    parameter int                MAX_CYCLE = 1000,
    parameter logic [DATA_W-1:0] CMP_MASK  = {DATA_W{1'b1}},
    parameter int                IDX_W     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arm,
    input  logic [ADDR_W-1:0]   eof_addr,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   pc,
    mem_result_checker_if.master mem,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [IDX_W:0]      err_cnt,
    output logic [IDX_W-1:0]    first_err_idx,
    output logic [DATA_W-1:0]   first_err_got,
    output logic [DATA_W-1:0]   first_err_exp,
    output logic [CNT_W-1:0]    run_cycles
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_RUN = CNT_W'(MAX_CYCLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W-1:0]   eof_q;
    logic [ADDR_W-1:0]   base_q;
    logic                rd_req_q;
    logic [IDX_W-1:0]    rd_idx_q;
    logic                cmp_valid;
    logic [IDX_W-1:0]    cmp_idx;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic                timeout_q;
    logic [IDX_W:0]      err_cnt_q;
    logic [IDX_W-1:0]    first_idx_q;
    logic [DATA_W-1:0]   first_got_q;
    logic [DATA_W-1:0]   first_exp_q;
    logic [CNT_W-1:0]    run_cycles_q;

    logic                mismatch;
    logic [IDX_W:0]      err_cnt_next;

    // Masked compare of the words returned for the index read last cycle.
    assign mismatch     = cmp_valid && (|((mem.dut_rdata ^ mem.ans_rdata) & CMP_MASK));
    assign err_cnt_next = err_cnt_q + {{IDX_W{1'b0}}, mismatch};

    assign mem.rd_req  = rd_req_q;
    assign mem.rd_idx  = rd_idx_q;
    assign mem.rd_addr = base_q + (ADDR_W'(rd_idx_q) << 2);

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = first_idx_q;
    assign first_err_got = first_got_q;
    assign first_err_exp = first_exp_q;
    assign run_cycles    = run_cycles_q;

    // Delay the read strobe and index by one cycle to line up with read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_valid <= 1'b0;
            cmp_idx   <= '0;
        end else begin
            cmp_valid <= rd_req_q;
            cmp_idx   <= rd_idx_q;
        end
    end

    // Control FSM plus result registers; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            eof_q        <= '0;
            base_q       <= '0;
            rd_req_q     <= 1'b0;
            rd_idx_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_got_q  <= '0;
            first_exp_q  <= '0;
            run_cycles_q <= '0;
        end else begin
            if (mismatch) begin
                err_cnt_q <= err_cnt_next;
                if (err_cnt_q == '0) begin
                    first_idx_q <= cmp_idx;
                    first_got_q <= mem.dut_rdata;
                    first_exp_q <= mem.ans_rdata;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state        <= RUN;
                        eof_q        <= eof_addr;
                        base_q       <= base_addr;
                        rd_idx_q     <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        err_cnt_q    <= '0;
                        first_idx_q  <= '0;
                        first_got_q  <= '0;
                        first_exp_q  <= '0;
                        run_cycles_q <= '0;
                    end
                end

                RUN: begin
                    run_cycles_q <= run_cycles_q + CNT_W'(1);
                    if (pc == eof_q) begin
                        state    <= SCAN;
                        rd_req_q <= 1'b1;
                        rd_idx_q <= '0;
                    end else if (run_cycles_q == LAST_RUN) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end
                end

                SCAN: begin
                    if (rd_idx_q == LAST_IDX) begin
                        state    <= DRAIN;
                        rd_req_q <= 1'b0;
                    end else begin
                        rd_idx_q <= rd_idx_q + IDX_W'(1);
                    end
                end

                DRAIN: begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (err_cnt_next == '0);
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_result_checker.sv
// Randomised scoreboard bench for mem_result_checker. A driver arms the
// checker, plays a fetch-address sequence and loads both memories; the
// expected report for every run is derived from the memory contents and
// the EOF position and queued. A monitor pops and compares on each rising
// edge of done, and also follows the read stream and reset behaviour.
module tb_mem_result_checker;

    localparam int          ADDR_W    = 32;
    localparam int          DATA_W    = 32;
    localparam int          DEPTH     = 32;
    localparam int          CNT_W     = 16;
    localparam int          MAX_CYCLE = 1000;
    localparam logic [31:0] MASK      = 32'h0000_FFFF;
    localparam int          IDX_W     = 5;

    typedef struct {
        int unsigned arm_edge;
        int          latency;
        bit          pass;
        bit          timeout;
        int          err_cnt;
        int          first_idx;
        logic [31:0] first_got;
        logic [31:0] first_exp;
        int          run_cycles;
        int          reads;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               arm;
    logic [ADDR_W-1:0]  eof_addr;
    logic [ADDR_W-1:0]  base_addr;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               done;
    logic               pass;
    logic               timeout;
    logic [IDX_W:0]     err_cnt;
    logic [IDX_W-1:0]   first_err_idx;
    logic [DATA_W-1:0]  first_err_got;
    logic [DATA_W-1:0]  first_err_exp;
    logic [CNT_W-1:0]   run_cycles;

    logic [31:0] dut_mem [DEPTH];
    logic [31:0] ans_mem [DEPTH];
    exp_t        sb_q [$];
    int unsigned cyc;
    int          total;
    int          bad;

    mem_result_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) mif ();

    mem_result_checker #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W),
        .MAX_CYCLE (MAX_CYCLE),
        .CMP_MASK  (MASK),
        .IDX_W     (IDX_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .eof_addr      (eof_addr),
        .base_addr     (base_addr),
        .pc            (pc),
        .mem           (mif),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .first_err_got (first_err_got),
        .first_err_exp (first_err_exp),
        .run_cycles    (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time-stamp arm and done.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories: data appears the cycle after rd_req.
    always @(posedge clk) begin
        if (mif.rd_req) begin
            mif.dut_rdata <= dut_mem[mif.rd_idx];
            mif.ans_rdata <= ans_mem[mif.rd_idx];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    // Reference report: count masked differences, note the lowest failing index.
    function automatic exp_t computeExpected(input int eof_at);
        exp_t e;
        e.arm_edge = 0; e.pass = 0; e.timeout = 0; e.err_cnt = 0; e.first_idx = 0;
        e.first_got = 0; e.first_exp = 0; e.reads = 0;
        if (eof_at >= 1 && eof_at <= MAX_CYCLE) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (((dut_mem[i] ^ ans_mem[i]) & MASK) != 0) begin
                    if (e.err_cnt == 0) begin
                        e.first_idx = i;
                        e.first_got = dut_mem[i];
                        e.first_exp = ans_mem[i];
                    end
                    e.err_cnt++;
                end
            end
            e.pass       = (e.err_cnt == 0);
            e.run_cycles = eof_at;
            e.latency    = eof_at + DEPTH + 1;
            e.reads      = DEPTH;
        end else begin
            e.timeout    = 1;
            e.run_cycles = MAX_CYCLE;
            e.latency    = MAX_CYCLE;
        end
        return e;
    endfunction

    function automatic logic [31:0] nonEof(input logic [31:0] eof);
        logic [31:0] v;
        v = $urandom;
        if (v == eof) v = ~v;
        return v;
    endfunction

    task automatic fillRandom(input int err_pct);
        for (int i = 0; i < DEPTH; i++) begin
            ans_mem[i] = $urandom;
            dut_mem[i] = ans_mem[i];
            if ($urandom_range(0, 99) < err_pct) dut_mem[i] = dut_mem[i] ^ $urandom;
        end
    endtask

    // Arm, play pc until EOF at RUN cycle eof_at (0 = never), then wait for
    // done, or pull reset once rd_idx reaches abort_idx when abort_idx >= 0.
    task automatic applyStimulus(input int eof_at, input int abort_idx, input logic [31:0] eof_val);
        exp_t e;
        bit   seen;
        e = computeExpected(eof_at);
        arm       = 1'b1;
        eof_addr  = eof_val;
        base_addr = $urandom & 32'hFFFF_FFFC;
        pc        = nonEof(eof_val);
        e.arm_edge = cyc + 1;
        if (abort_idx < 0) sb_q.push_back(e);
        @(posedge clk); #1;
        arm       = 1'b0;
        eof_addr  = nonEof(eof_val);
        base_addr = $urandom;
        seen      = 0;
        for (int n = 1; n <= MAX_CYCLE + DEPTH + 8; n++) begin
            pc = (n == eof_at) ? eof_val : nonEof(eof_val);
            @(posedge clk); #1;
            if (abort_idx >= 0 && mif.rd_req && int'(mif.rd_idx) == abort_idx) begin
                seen = 1;
                break;
            end
            if (abort_idx < 0 && done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("wait_bound", 64'(seen), 64'd1);
        if (abort_idx >= 0) begin
            rst_n = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    // Monitor: reset values, cleared results after arm, read stream, scoreboard.
    initial begin : monitor
        exp_t        e;
        bit          prev_done;
        bit          clear_pending;
        int          rd_exp_idx;
        int          rd_seen;
        logic [31:0] mon_base;
        prev_done = 0; clear_pending = 0; rd_exp_idx = 0; rd_seen = 0; mon_base = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("rst_busy", 64'(busy), 0);
                checkOutput("rst_done", 64'(done), 0);
                checkOutput("rst_pass", 64'(pass), 0);
                checkOutput("rst_timeout", 64'(timeout), 0);
                checkOutput("rst_err_cnt", 64'(err_cnt), 0);
                checkOutput("rst_first_idx", 64'(first_err_idx), 0);
                checkOutput("rst_first_got", 64'(first_err_got), 0);
                checkOutput("rst_first_exp", 64'(first_err_exp), 0);
                checkOutput("rst_run_cycles", 64'(run_cycles), 0);
                checkOutput("rst_rd_req", 64'(mif.rd_req), 0);
                checkOutput("rst_rd_idx", 64'(mif.rd_idx), 0);
                checkOutput("rst_rd_addr", 64'(mif.rd_addr), 0);
                prev_done = 0;
                clear_pending = 0;
            end else begin
                if (clear_pending) begin
                    checkOutput("arm_busy", 64'(busy), 1);
                    checkOutput("arm_done", 64'(done), 0);
                    checkOutput("arm_pass", 64'(pass), 0);
                    checkOutput("arm_timeout", 64'(timeout), 0);
                    checkOutput("arm_err_cnt", 64'(err_cnt), 0);
                    checkOutput("arm_first_idx", 64'(first_err_idx), 0);
                    checkOutput("arm_first_got", 64'(first_err_got), 0);
                    checkOutput("arm_first_exp", 64'(first_err_exp), 0);
                    checkOutput("arm_run_cycles", 64'(run_cycles), 0);
                    clear_pending = 0;
                end
                if (done && !prev_done) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("sb_has_entry", 0, 1);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("latency", 64'(cyc - e.arm_edge), 64'(e.latency));
                        checkOutput("pass", 64'(pass), 64'(e.pass));
                        checkOutput("timeout", 64'(timeout), 64'(e.timeout));
                        checkOutput("err_cnt", 64'(err_cnt), 64'(e.err_cnt));
                        checkOutput("first_err_idx", 64'(first_err_idx), 64'(e.first_idx));
                        checkOutput("first_err_got", 64'(first_err_got), 64'(e.first_got));
                        checkOutput("first_err_exp", 64'(first_err_exp), 64'(e.first_exp));
                        checkOutput("run_cycles", 64'(run_cycles), 64'(e.run_cycles));
                        checkOutput("read_count", 64'(rd_seen), 64'(e.reads));
                        checkOutput("done_busy", 64'(busy), 0);
                    end
                end
                if (mif.rd_req) begin
                    checkOutput("rd_idx", 64'(mif.rd_idx), 64'(rd_exp_idx));
                    checkOutput("rd_addr", 64'(mif.rd_addr), 64'(mon_base + 32'(rd_exp_idx) * 4));
                    rd_exp_idx++;
                    rd_seen++;
                end
                if (arm) begin
                    clear_pending = 1;
                    rd_exp_idx = 0;
                    rd_seen = 0;
                    mon_base = base_addr;
                end
                prev_done = done;
            end
        end
    end

    // Driver: directed scenarios followed by random runs, each re-armed from DONE.
    initial begin : driver
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0; arm = 1'b0; eof_addr = '0; base_addr = '0; pc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = '0;
            ans_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] all-match run");
        fillRandom(0);
        applyStimulus(50, -1, 32'h0001_0040);

        $display("[TB] two mismatches");
        fillRandom(0);
        dut_mem[3] = 32'h5;
        ans_mem[3] = 32'h6;
        dut_mem[17] = ans_mem[17] ^ 32'h0000_0100;
        applyStimulus($urandom_range(10, 60), -1, 32'h0001_0040);

        $display("[TB] timeout");
        fillRandom(20);
        applyStimulus(0, -1, $urandom);

        $display("[TB] eof on last budget cycle");
        fillRandom(10);
        applyStimulus(MAX_CYCLE, -1, $urandom);

        $display("[TB] mask upper bits");
        fillRandom(0);
        for (int i = 0; i < DEPTH; i += 3) dut_mem[i] = ans_mem[i] ^ 32'hFFFF_0000;
        applyStimulus(12, -1, $urandom);
        dut_mem[7] = dut_mem[7] ^ 32'h1;
        applyStimulus(7, -1, $urandom);

        $display("[TB] reset mid-scan then full rescan");
        fillRandom(30);
        applyStimulus(20, 10, $urandom);
        fillRandom(30);
        applyStimulus(30, -1, $urandom);

        $display("[TB] random runs");
        for (int r = 0; r < 8; r++) begin
            fillRandom($urandom_range(0, 40));
            applyStimulus($urandom_range(1, 120), -1, $urandom);
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("sb_empty", 64'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_result_checker.md
Name: mem_result_checker

Overview:
- Synthesizable, parametrised successor to the end-of-program memory check in the chip testbench.
- Arms on a pulse, then watches the instruction fetch address for the end-of-text (EOF) address, with a cycle-budget timeout.
- On EOF it scans DEPTH words of data memory against an answer memory through a pipelined synchronous-read port, with a masked compare.
- Reports pass/fail, error count, first mismatch details and cycles used; sits beside CHIP in bench or FPGA harness.

Parameters:
- ADDR_W, 32, address width of pc, eof_addr, base_addr, rd_addr
- DATA_W, 32, word width compared
- DEPTH, 32, number of words scanned (≥2)
- CNT_W, 16, width of cycle counter
- MAX_CYCLE, 1000, cycle budget in RUN before timeout (< 2^CNT_W)
- CMP_MASK, {DATA_W{1'b1}}, bit mask applied before compare
- IDX_W, $clog2(DEPTH), index width (derived)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- arm  input  1  single-cycle start pulse; latches eof_addr, base_addr
- eof_addr  input  ADDR_W  pc value that ends the program
- base_addr  input  ADDR_W  byte address of data word 0
- pc  input  ADDR_W  CHIP instruction fetch address (mem_addr_I)
- rd_req  output  1  read strobe to both memories
- rd_idx  output  IDX_W  word index being read
- rd_addr  output  ADDR_W  base_addr_latched + 4*rd_idx
- dut_rdata  input  DATA_W  data memory word, valid 1 cycle after rd_req
- ans_rdata  input  DATA_W  answer word, valid 1 cycle after rd_req
- busy  output  1  high in RUN, SCAN, DRAIN
- done  output  1  high in DONE
- pass  output  1  valid while done
- timeout  output  1  valid while done
- err_cnt  output  IDX_W+1  number of mismatching words
- first_err_idx  output  IDX_W  index of first mismatch
- first_err_got  output  DATA_W  dut word at first mismatch
- first_err_exp  output  DATA_W  answer word at first mismatch
- run_cycles  output  CNT_W  cycles spent in RUN

Behaviour:
- Reset (async, any state): state=IDLE. rd_req, busy, done, pass, timeout = 0. err_cnt, first_err_*, run_cycles, rd_idx = 0. Latched addresses = 0.
- States: IDLE, RUN, SCAN, DRAIN, DONE.
- IDLE: arm=1 -> latch eof/base, clear counters, go to RUN.
- RUN: run_cycles increments each cycle. If pc==eof_latched -> SCAN, rd_idx=0. Else if run_cycles==MAX_CYCLE-1 -> DONE, timeout=1, pass=0, no scan. If both in the same cycle, EOF wins.
- SCAN: rd_req=1 every cycle; rd_idx goes 0..DEPTH-1, one per cycle. After idx DEPTH-1 -> DRAIN.
- Compare stage: registered valid/idx delayed 1 cycle. When valid, mismatch = |((dut_rdata^ans_rdata)&CMP_MASK).
  - On mismatch, err_cnt += 1.
  - On the first mismatch only (err_cnt==0), capture idx, got, exp.
- DRAIN: last compare completes -> DONE, pass = (final err_cnt==0).
- Latency: EOF seen at cycle t -> rd_req cycles t+1..t+DEPTH -> done=1 at t+DEPTH+2.
- DONE: outputs held stable. arm=1 -> clear results, re-latch, go to RUN (re-arm).
- arm ignored in RUN/SCAN/DRAIN.
- err_cnt width holds DEPTH exactly; no saturation.
- rd_idx does not wrap; it holds DEPTH-1 after SCAN.
- CMP_MASK bits 0 are don't-care in both operands.
- Reset mid-scan: immediate abort to IDLE, all outputs cleared; no partial result is visible.

Test Plan:
- Match: arm, eof=0x10040, pc reaches 0x10040 after 50 cycles, all words equal -> done at +DEPTH+2, pass=1, err_cnt=0, run_cycles=50.
- Two mismatches: idx 3 (got 0x5, exp 0x6) and idx 17 -> err_cnt=2, first_err_idx=3, got=0x5, exp=0x6, pass=0.
- Timeout: MAX_CYCLE=1000, pc never hits eof -> done at cycle 1000 after arm, timeout=1, pass=0, rd_req never asserted.
- Edge tie: pc==eof on the same cycle run_cycles==MAX_CYCLE-1 -> scan occurs, timeout=0.
- Mask: CMP_MASK=0x0000FFFF, words differ only in bits 31:16 -> pass=1. Differ in bit 0 -> err_cnt=1.
- Reset at SCAN idx 10 -> outputs 0 asynchronously. Re-arm -> full scan, rd_idx restarts at 0.
- Back-to-back re-arm from DONE -> results cleared the next cycle, second run reports independently.
